// File: rtl/input_port_requester.sv
// -----------------------------------------------------------------------------
// input_port_requester
//
// Buffers single-flit packets from one upstream input port. It requests the
// output-port arbiter that the head flit is addressed to. The destination is
// taken from the low DEST_W bits of the flit. A granted head flit leaves the
// buffer in the same cycle as the grant.
//
// Port summary
//   clk        in   1             clock, rising edge
//   rst_b      in   1             synchronous active-low reset
//   in_valid   in   1             upstream flit valid
//   in_data    in   DATA_WIDTH    upstream flit, [DEST_W-1:0] = destination
//   in_ready   out  1             a flit offered this cycle is accepted
//   out_req    out  NUM_OF_OUTS   one-hot request to the output arbiters
//   out_grant  in   NUM_OF_OUTS   combinational grant, same cycle as out_req
//   out_data   out  DATA_WIDTH    head flit, meaningful while out_req != 0
//   count      out  CW            number of buffered flits
//   starve     out  1             head flit has waited STARVE_LIMIT cycles
//   grant_err  out  1             sticky: a grant arrived without a request
//
// NUM_OF_OUTS and FIFO_DEPTH must be powers of two, each at least 2.
// -----------------------------------------------------------------------------
module input_port_requester #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_OF_OUTS  = 2,
  parameter int DEST_W       = $clog2(NUM_OF_OUTS),
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic [NUM_OF_OUTS-1:0]          out_req,
  input  logic [NUM_OF_OUTS-1:0]          out_grant,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            starve,
  output logic                            grant_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic [WW-1:0]         wait_cnt;
  logic [WW-1:0]         wait_cnt_nxt;

  logic                  push;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [DEST_W-1:0]     head_dest;
  logic                  stray_grant;

  // ---------------------------------------------------------------------------
  // Head-of-line request
  // ---------------------------------------------------------------------------
  // The head is read straight from storage. A flit written this cycle lands
  // at wr_ptr and only becomes visible after the edge, so there is no
  // same-cycle bypass. While the buffer is empty, out_data shows a stale
  // entry and must not be used.
  assign out_data  = mem[rd_ptr];
  assign head_dest = out_data[DEST_W-1:0];

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  assign out_req = empty ? '0 : (NUM_OF_OUTS'(1) << head_dest);

  // Masking with out_req means that a grant on a port we did not request
  // can never remove a flit.
  assign pop         = |(out_req & out_grant);
  assign stray_grant = |(out_grant & ~out_req);

  // A full buffer still accepts a flit when the head leaves in the same
  // cycle. This puts out_grant on a combinational path to in_ready.
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Starvation counter
  // ---------------------------------------------------------------------------
  // When the buffer is non-empty, out_req is non-zero. So "no pop" here means
  // a request was left ungranted this cycle.
  always_comb begin
    // NOTE: default assignment first so every path drives wait_cnt_nxt and
    // no latch is inferred.
    wait_cnt_nxt = wait_cnt;
    if (pop || empty) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_SAT) begin
      wait_cnt_nxt = wait_cnt + WW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // starve is registered from the next counter value, so it rises in the
  // same cycle that wait_cnt reaches the limit. It drops in the cycle after
  // the pop that clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      // NOTE: state updates in always_ff use non-blocking assignments so
      // every register samples pre-edge values.
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      starve    <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap by plain overflow.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      wait_cnt <= wait_cnt_nxt;
      starve   <= (wait_cnt_nxt == WAIT_SAT);

      if (stray_grant) begin
        grant_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flit storage
  // ---------------------------------------------------------------------------
  // NOTE: the data array has no reset. Clearing the pointers and count is
  // enough to discard its contents, and it keeps the array mappable to
  // plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_input_port_requester.sv
// -----------------------------------------------------------------------------
// tb_input_port_requester
//
// Directed bench for input_port_requester with default parameters
// (8-bit flits, 2 outputs, depth 4, starve limit 8). Inputs change 1 ns
// after the rising edge. Outputs are sampled 1-2 ns after that, well away
// from the next edge.
// -----------------------------------------------------------------------------
module tb_input_port_requester;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [1:0] out_req;
  logic [1:0] out_grant;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       starve;
  logic       grant_err;

  // The grant either mirrors the request or is driven directly.
  logic       grant_tie;
  logic [1:0] grant_drv;
  assign out_grant = grant_tie ? out_req : grant_drv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  input_port_requester dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_req   (out_req),
    .out_grant (out_grant),
    .out_data  (out_data),
    .count     (count),
    .starve    (starve),
    .grant_err (grant_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] flits [4];
  int         sent;
  int         rcvd;

  initial begin
    rst_b     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    grant_tie = 1'b0;
    grant_drv = 2'b00;
    tick();
    tick();
    rst_b = 1'b1;
    #1;

    // Reset state
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_req",   32'(out_req),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_starve",    32'(starve),    32'd0);
    check("rst_grant_err", 32'(grant_err), 32'd0);

    // Single flit, grant tied to the request: it pops in its first head cycle
    grant_tie = 1'b1;
    push_one(8'h05);
    #1;
    check("single_req",   32'(out_req),  32'h2);
    check("single_data",  32'(out_data), 32'h05);
    check("single_count", 32'(count),    32'd1);
    tick();
    check("single_drain_count", 32'(count),   32'd0);
    check("single_drain_req",   32'(out_req), 32'd0);

    // Fill to capacity with the grant held low
    grant_tie = 1'b0;
    grant_drv = 2'b00;
    flits[0] = 8'h10;
    flits[1] = 8'h21;
    flits[2] = 8'h32;
    flits[3] = 8'h43;
    for (int i = 0; i < 4; i++) push_one(flits[i]);
    #1;
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_req", 32'(out_req),  32'h1);
    check("full_head",     32'(out_data), 32'h10);

    // Offer a flit to the full buffer with no grant: it is refused
    push_one(8'h66);
    check("full_reject_count", 32'(count),    32'd4);
    check("full_reject_head",  32'(out_data), 32'h10);

    // Grant the head while offering a new flit: pop and push together
    in_valid  = 1'b1;
    in_data   = 8'h54;
    grant_drv = 2'b01;
    #1;
    check("full_pushpop_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid  = 1'b0;
    grant_drv = 2'b00;
    #1;
    check("full_pushpop_count", 32'(count),   32'd4);
    check("full_pushpop_req",   32'(out_req), 32'h2);

    // Drain back to back: one flit per cycle, in arrival order
    grant_tie = 1'b1;
    flits[0] = 8'h21;
    flits[1] = 8'h32;
    flits[2] = 8'h43;
    flits[3] = 8'h54;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_data%0d", i), 32'(out_data), 32'(flits[i]));
      check($sformatf("drain_req%0d", i),  32'(out_req),  32'h1 << (flits[i] & 8'h1));
      tick();
    end
    check("drain_count", 32'(count), 32'd0);

    // Starvation: head of dest 0 waits 8 cycles ungranted
    grant_tie = 1'b0;
    grant_drv = 2'b00;
    push_one(8'h00);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("starve_low_c%0d", c), 32'(starve), 32'd0);
      tick();
    end
    check("starve_c9", 32'(starve), 32'd1);
    tick();
    check("starve_c10", 32'(starve), 32'd1);
    grant_drv = 2'b01;
    tick();
    grant_drv = 2'b00;
    check("starve_c11",       32'(starve), 32'd0);
    check("starve_c11_count", 32'(count),  32'd0);

    // Unrequested grant: no pop, and a sticky error flag
    push_one(8'h01);
    #1;
    check("gerr_req", 32'(out_req), 32'h2);
    grant_drv = 2'b01;
    tick();
    grant_drv = 2'b00;
    check("gerr_set",      32'(grant_err), 32'd1);
    check("gerr_no_pop",   32'(count),     32'd1);
    check("gerr_head",     32'(out_data),  32'h01);
    tick();
    tick();
    check("gerr_sticky",   32'(grant_err), 32'd1);

    // Reset mid-stream discards buffered flits and clears the flag
    for (int i = 0; i < 3; i++) push_one(8'(8'h70 + i));
    check("midrst_pre_count", 32'(count), 32'd4);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    #1;
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_out_req",   32'(out_req),   32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_grant_err", 32'(grant_err), 32'd0);
    check("midrst_starve",    32'(starve),    32'd0);

    // Streaming: 10 flits with alternating destination and random grants
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
      in_valid  = (sent < 10);
      in_data   = 8'((sent << 1) | (sent & 1));
      grant_drv = ($urandom_range(0, 1) == 1) ? out_req : 2'b00;
      #1;
      check("stream_req", 32'(out_req),
            (exp_q.size() == 0) ? 32'd0 : (32'h1 << exp_q[0][0]));
      if (out_req != 2'b00 && grant_drv != 2'b00 && exp_q.size() != 0) begin
        check($sformatf("stream_data%0d", rcvd), 32'(out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        rcvd++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    grant_drv = 2'b00;
    #1;
    check("stream_received",  32'(rcvd),      32'd10);
    check("stream_count",     32'(count),     32'd0);
    check("stream_grant_err", 32'(grant_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/input_port_requester.md
INPUT_PORT_REQUESTER -- requirements
Module: input_port_requester

Interface
REQ-001 Parameters SHALL be as follows; NUM_OF_OUTS SHALL be a power of two >= 2 and FIFO_DEPTH a power of two >= 2.
- DATA_WIDTH, default 8: flit width.
- NUM_OF_OUTS, default 2: number of output-port arbiters served.
- DEST_W, default $clog2(NUM_OF_OUTS): destination field width.
- FIFO_DEPTH, default 4: flit buffer entries.
- STARVE_LIMIT, default 8: wait cycles before starve asserts.
REQ-002 Ports SHALL be as follows; reset is synchronous and active-low, and the block uses one clock.
- clk  in  1  clock, rising edge.
- rst_b  in  1  synchronous active-low reset.
- in_valid  in  1  upstream flit valid.
- in_data  in  DATA_WIDTH  upstream flit; bits [DEST_W-1:0] = destination output index.
- in_ready  out  1  buffer can accept a flit.
- out_req  out  NUM_OF_OUTS  one-hot request to the output-port arbiters.
- out_grant  in  NUM_OF_OUTS  grant from the arbiters, combinational, same cycle as out_req.
- out_data  out  DATA_WIDTH  head flit, valid whenever out_req != 0.
- count  out  $clog2(FIFO_DEPTH+1)  flits buffered.
- starve  out  1  head flit has waited >= STARVE_LIMIT cycles.
- grant_err  out  1  sticky protocol-error flag.

Function
REQ-003 The block SHALL buffer single-flit packets in a FIFO of FIFO_DEPTH entries; a push occurs when in_valid && in_ready.
REQ-004 in_ready SHALL equal (count < FIFO_DEPTH) || pop, so a push into a full FIFO is accepted in a cycle that also pops.
REQ-005 When count == 0, out_req SHALL be all-zero and out_data SHALL hold the last value (don't-care).
REQ-006 When count > 0, out_req SHALL be one-hot, with bit head.data[DEST_W-1:0] set, driven combinationally from the FIFO head.
REQ-007 pop SHALL equal |(out_req & out_grant), and the head SHALL be removed at the end of that cycle (zero-cycle grant latency).
REQ-008 out_req SHALL stay asserted on consecutive cycles while the FIFO is non-empty; back-to-back flits SHALL pop one per cycle when granted every cycle.
REQ-009 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed FIFO_DEPTH nor underflow.
REQ-010 Read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated flits.
REQ-011 A push into an empty FIFO SHALL make that flit the head on the next cycle; there is no same-cycle bypass.
REQ-012 wait_cnt, an internal counter of width $clog2(STARVE_LIMIT+1), SHALL behave as follows:
- clear on pop or when count == 0;
- otherwise increment each cycle out_req != 0 with no grant;
- saturate at STARVE_LIMIT.
REQ-013 starve SHALL be registered and equal (wait_cnt == STARVE_LIMIT); it SHALL deassert the cycle after a pop.
REQ-014 grant_err SHALL set the cycle after any out_grant bit is high while the corresponding out_req bit is low.
REQ-015 grant_err SHALL stay set until reset; an unrequested grant SHALL never cause a pop.

Reset
REQ-016 While rst_b is low at a clk edge, the block SHALL clear pointers, count, wait_cnt, starve and grant_err to 0.
REQ-017 Buffered flits SHALL be discarded on reset, including reset mid-stream.
REQ-018 The cycle after reset, out_req SHALL be 0 and in_ready SHALL be 1.
REQ-019 The FIFO data storage SHALL NOT require reset.

Verification
REQ-020 Push 0x05 (dest 1), grant tied to out_req -> next cycle out_req=2'b10, out_data=0x05, pop same cycle, count returns to 0.
REQ-021 Push 4 flits with grant held low -> count=4, in_ready=0; assert grant with in_valid high -> pop and push same cycle, count stays 4, FIFO order preserved.
REQ-022 Head dest 0, grant low for 8 cycles -> starve=1 on cycle 9; grant on cycle 10 -> starve=0 on cycle 11.
REQ-023 out_grant=2'b01 while out_req=2'b10 -> no pop, grant_err=1 next cycle and held until rst_b low.
REQ-024 Push 3 flits, assert rst_b=0 for one cycle mid-stream -> count=0, out_req=0, in_ready=1 after reset.
REQ-025 Stream 10 flits with alternating dest and random grants -> output order matches input order and pointers wrap cleanly.
